// File: rtl/cpu_pkg.sv
// Shared pipeline-control types: register address width, in-flight writer slot and
// hazard-controller FSM encoding.
package cpu_pkg;

  localparam int REG_AW = 4;
  localparam logic [REG_AW-1:0] R0 = '0;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              is_load;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '0;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } hcu_state_t;

  // R0 is hardwired zero, so a source naming it never depends on an in-flight writer.
  function automatic logic src_hits(input logic used, input logic [REG_AW-1:0] src,
                                    input slot_t s);
    return used && (src != R0) && s.valid && (src == s.rd);
  endfunction

endpackage

// File: rtl/hazard_shadow_pipe.sv
// Three-slot shadow of the DX/XM/MW writers; advances every edge and takes a new
// entry (possibly a bubble) from the ID stage.
import cpu_pkg::*;

module hazard_shadow_pipe (
  input  logic  clk,
  input  logic  rst,
  input  slot_t entry,
  output slot_t dx,
  output slot_t xm,
  output slot_t mw
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dx <= SLOT_BUBBLE;
      xm <= SLOT_BUBBLE;
      mw <= SLOT_BUBBLE;
    end else begin
      mw <= xm;
      xm <= dx;
      dx <= entry;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// ID-stage hazard controller: load-use stall, taken-branch flush, HLT drain
// sequencing and a saturating stall-cycle counter.
import cpu_pkg::*;

module hazard_control_unit #(
  parameter int REG_AW   = cpu_pkg::REG_AW,
  parameter int STALL_CW = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_AW-1:0]   id_rs,
  input  logic [REG_AW-1:0]   id_rt,
  input  logic                id_use_rs,
  input  logic                id_use_rt,
  input  logic                id_is_store,
  input  logic                id_regwrite,
  input  logic                id_memread,
  input  logic [REG_AW-1:0]   id_rd,
  input  logic                id_halt,
  input  logic                ex_branch_taken,
  output logic                stall,
  output logic                flush_ifid,
  output logic                flush_idex,
  output logic                pc_write,
  output logic                halted,
  output logic [STALL_CW-1:0] stall_count
);

  hcu_state_t state;
  slot_t      entry;
  slot_t      dx;
  slot_t      xm;
  slot_t      mw;
  logic       load_use;
  logic       flush;
  logic       pipe_empty;
  logic       halt_go;

  hazard_shadow_pipe u_shadow (
    .clk   (clk),
    .rst   (rst),
    .entry (entry),
    .dx    (dx),
    .xm    (xm),
    .mw    (mw)
  );

  // Only a load one stage ahead is unforwardable; store data (rt) rides forwardmm instead.
  assign load_use = dx.is_load &&
                    (src_hits(id_use_rs, id_rs, dx) ||
                     (src_hits(id_use_rt, id_rt, dx) && !id_is_store));

  assign pipe_empty = !dx.valid && !xm.valid && !mw.valid;

  always_comb begin
    stall = 1'b0;
    flush = 1'b0;
    case (state)
      ST_RUN: begin
        flush = ex_branch_taken;
        stall = load_use && !ex_branch_taken;
      end
      ST_DRAIN,
      ST_HALTED: stall = 1'b1;
      default: begin
        stall = 1'b0;
        flush = 1'b0;
      end
    endcase
  end

  assign flush_ifid = flush;
  assign flush_idex = flush;
  assign pc_write   = !stall && !halted;
  assign halt_go    = (state == ST_RUN) && id_valid && id_halt && !ex_branch_taken && !stall;

  // HLT itself never occupies a slot, so drain completes once the older writers retire.
  always_comb begin
    entry         = SLOT_BUBBLE;
    entry.rd      = id_rd;
    entry.is_load = id_memread;
    entry.valid   = (state == ST_RUN) && id_valid && id_regwrite && !id_halt &&
                    (id_rd != R0) && !stall && !flush;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_RUN;
      halted <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (halt_go) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (pipe_empty) begin
            state  <= ST_HALTED;
            halted <= 1'b1;
          end
        end
        ST_HALTED: begin
          state  <= ST_HALTED;
          halted <= 1'b1;
        end
        default: begin
          state  <= ST_RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
    end else if (stall && (state != ST_HALTED) && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

  // The drain freezes fetch, so no branch can be resolving in EX while draining.
  a_no_branch_in_drain: assert property (@(posedge clk) disable iff (!rst)
    !((state == ST_DRAIN) && ex_branch_taken));

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed scenarios plus a randomized
// run against a timeline model of the writers issued in the last three cycles.
module tb_hazard_control_unit;

  localparam int AW = 4;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          id_valid;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rt;
  logic          id_use_rs;
  logic          id_use_rt;
  logic          id_is_store;
  logic          id_regwrite;
  logic          id_memread;
  logic [AW-1:0] id_rd;
  logic          id_halt;
  logic          ex_branch_taken;
  logic          stall;
  logic          flush_ifid;
  logic          flush_idex;
  logic          pc_write;
  logic          halted;
  logic [CW-1:0] stall_count;

  int n_cmp = 0;
  int n_fail = 0;

  hazard_control_unit #(.REG_AW(AW), .STALL_CW(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_use_rs       (id_use_rs),
    .id_use_rt       (id_use_rt),
    .id_is_store     (id_is_store),
    .id_regwrite     (id_regwrite),
    .id_memread      (id_memread),
    .id_rd           (id_rd),
    .id_halt         (id_halt),
    .ex_branch_taken (ex_branch_taken),
    .stall           (stall),
    .flush_ifid      (flush_ifid),
    .flush_idex      (flush_idex),
    .pc_write        (pc_write),
    .halted          (halted),
    .stall_count     (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                       input bit st, input bit rw, input bit mr, input int rd,
                       input bit h, input bit br);
    id_valid        = v;
    id_rs           = rs[AW-1:0];
    id_rt           = rt[AW-1:0];
    id_use_rs       = urs;
    id_use_rt       = urt;
    id_is_store     = st;
    id_regwrite     = rw;
    id_memread      = mr;
    id_rd           = rd[AW-1:0];
    id_halt         = h;
    ex_branch_taken = br;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle();
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({stall, flush_ifid, flush_idex, pc_write, halted} !== 5'b00010) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %b want 00010",
               {stall, flush_ifid, flush_idex, pc_write, halted});
    end
    n_cmp++;
    if (stall_count !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_count: got %0d want 0", stall_count);
    end
    #1;
    rst = 1'b1;
  endtask

  task automatic test_load_use();
    do_reset();
    @(negedge clk);
    drive(1, 2, 0, 1, 0, 0, 1, 1, 1, 0, 0);
    @(negedge clk);
    drive(1, 1, 4, 1, 1, 0, 1, 0, 5, 0, 0);
    #1;
    n_cmp++;
    if ({stall, pc_write} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL lu_stall: stall,pc_write=%b want 10", {stall, pc_write});
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({stall, pc_write} !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL lu_release: stall,pc_write=%b want 01", {stall, pc_write});
    end
    n_cmp++;
    if (stall_count !== 8'd1) begin
      n_fail++;
      $display("[TB] FAIL lu_count: got %0d want 1", stall_count);
    end
  endtask

  task automatic test_store_forward();
    do_reset();
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    @(negedge clk);
    drive(1, 3, 1, 1, 1, 1, 0, 0, 0, 0, 0);
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL sw_rt_nostall: stall=%b want 0", stall);
    end
    drive(1, 1, 3, 1, 1, 1, 0, 0, 0, 0, 0);
    #1;
    n_cmp++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL sw_rs_stall: stall=%b want 1", stall);
    end
  endtask

  task automatic test_no_stall();
    do_reset();
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0);
    @(negedge clk);
    drive(1, 2, 0, 1, 0, 0, 1, 0, 6, 0, 0);
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL alu_fwd: stall=%b want 0", stall);
    end
    do_reset();
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    @(negedge clk);
    drive(1, 0, 0, 1, 1, 0, 1, 0, 3, 0, 0);
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL r0_load: stall=%b want 0", stall);
    end
  endtask

  task automatic test_branch_flush();
    do_reset();
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    @(negedge clk);
    drive(1, 1, 0, 1, 0, 0, 1, 1, 1, 0, 1);
    #1;
    n_cmp++;
    if ({stall, flush_ifid, flush_idex} !== 3'b011) begin
      n_fail++;
      $display("[TB] FAIL br_override: stall,fifid,fidex=%b want 011",
               {stall, flush_ifid, flush_idex});
    end
    @(negedge clk);
    drive(1, 1, 0, 1, 0, 0, 1, 0, 5, 0, 0);
    #1;
    n_cmp++;
    if ({stall, flush_ifid, stall_count} !== {2'b00, 8'd0}) begin
      n_fail++;
      $display("[TB] FAIL br_bubble: stall=%b flush=%b count=%0d want 0 0 0",
               stall, flush_ifid, stall_count);
    end
  endtask

  task automatic test_halt_drain();
    do_reset();
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    #1;
    n_cmp++;
    if ({stall, halted} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL hlt_issue: stall,halted=%b want 00", {stall, halted});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if ({stall, pc_write, halted} !== 3'b100) begin
        n_fail++;
        $display("[TB] FAIL drain_%0d: stall,pc_write,halted=%b want 100", i,
                 {stall, pc_write, halted});
      end
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if ({stall, pc_write, halted, stall_count} !== {3'b101, 8'd3}) begin
        n_fail++;
        $display("[TB] FAIL halted_%0d: stall,pc_write,halted=%b count=%0d want 101 3", i,
                 {stall, pc_write, halted}, stall_count);
      end
    end
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if ({stall, halted, stall_count} !== {2'b10, 8'd1}) begin
      n_fail++;
      $display("[TB] FAIL pre_rst_drain: stall=%b halted=%b count=%0d want 1 0 1",
               stall, halted, stall_count);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({stall, halted, pc_write, stall_count} !== {3'b001, 8'd0}) begin
      n_fail++;
      $display("[TB] FAIL rst_in_drain: stall=%b halted=%b pc_write=%b count=%0d want 0 0 1 0",
               stall, halted, pc_write, stall_count);
    end
    @(negedge clk);
    rst = 1'b1;
    idle();
  endtask

  task automatic test_saturation();
    do_reset();
    // LW R1 that also reads R1: stalls every second cycle against its own predecessor.
    @(negedge clk);
    drive(1, 1, 0, 1, 0, 0, 1, 1, 1, 0, 0);
    for (int c = 1; c <= 2 * CMAX + 40; c++) begin
      @(negedge clk);
      #1;
      if (c == 2 * CMAX - 2) begin
        n_cmp++;
        if (stall_count !== 8'(CMAX - 1)) begin
          n_fail++;
          $display("[TB] FAIL sat_near: count=%0d want %0d", stall_count, CMAX - 1);
        end
      end
      if (c >= 2 * CMAX && (c % 10) == 0) begin
        n_cmp++;
        if (stall_count !== 8'(CMAX)) begin
          n_fail++;
          $display("[TB] FAIL sat_hold: count=%0d want %0d", stall_count, CMAX);
        end
      end
    end
  endtask

  // Writers issued 1, 2 and 3 cycles ago, in program order; index 0 is the youngest.
  typedef struct {
    bit valid;
    int rd;
    bit load;
  } writer_t;

  task automatic test_random();
    writer_t issued[3];
    int      mode;
    int      count;
    int      halt_age;
    bit      exp_stall;
    bit      exp_flush;
    bit      exp_halted;
    bit      hazard;
    bit      v, urs, urt, st, rw, mr, h, br;
    int      rs, rt, rd;

    do_reset();
    foreach (issued[k]) issued[k] = '{0, 0, 0};
    mode = 0;
    count = 0;
    halt_age = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (mode == 2 && halt_age > 3) begin
        rst = 1'b0;
        #2;
        rst = 1'b1;
        foreach (issued[k]) issued[k] = '{0, 0, 0};
        mode = 0;
        count = 0;
        halt_age = 0;
      end
      v   = ($urandom_range(0, 3) != 0);
      rs  = $urandom_range(0, 3);
      rt  = $urandom_range(0, 3);
      urs = $urandom_range(0, 1);
      urt = $urandom_range(0, 1);
      st  = ($urandom_range(0, 3) == 0);
      rw  = ($urandom_range(0, 2) != 0);
      mr  = $urandom_range(0, 1);
      rd  = $urandom_range(0, 3);
      h   = ($urandom_range(0, 39) == 0);
      br  = (mode == 0) && ($urandom_range(0, 7) == 0);
      drive(v, rs, rt, urs, urt, st, rw, mr, rd, h, br);
      #1;

      hazard = issued[0].valid && issued[0].load &&
               ((urs && rs != 0 && rs == issued[0].rd) ||
                (urt && !st && rt != 0 && rt == issued[0].rd));
      exp_halted = (mode == 2);
      exp_stall  = (mode != 0) || (hazard && !br);
      exp_flush  = (mode == 0) && br;

      n_cmp++;
      if ({stall, flush_ifid, flush_idex, pc_write, halted} !==
          {exp_stall, exp_flush, exp_flush, !exp_stall && !exp_halted, exp_halted}) begin
        n_fail++;
        $display("[TB] FAIL rnd_ctl@%0d: got %b want %b", cyc,
                 {stall, flush_ifid, flush_idex, pc_write, halted},
                 {exp_stall, exp_flush, exp_flush, !exp_stall && !exp_halted, exp_halted});
      end
      n_cmp++;
      if (stall_count !== count[CW-1:0]) begin
        n_fail++;
        $display("[TB] FAIL rnd_count@%0d: got %0d want %0d", cyc, stall_count, count);
      end

      if (exp_stall && mode != 2 && count < CMAX) count++;
      if (mode == 1 && !issued[0].valid && !issued[1].valid && !issued[2].valid) mode = 2;
      else if (mode == 0 && v && h && !br && !exp_stall) mode = 1;
      if (mode == 2) halt_age++;
      issued[2] = issued[1];
      issued[1] = issued[0];
      issued[0] = '{(mode_was_run(exp_halted, exp_stall, exp_flush, h)) && v && rw && rd != 0
                    && !exp_stall && !exp_flush && !h, rd, mr};
    end
    idle();
  endtask

  // A new writer can issue only while running (never during drain or halt, both of which stall).
  function automatic bit mode_was_run(input bit was_halted, input bit was_stall,
                                      input bit was_flush, input bit was_hlt);
    return !was_halted && !was_stall && !was_flush && !was_hlt;
  endfunction

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_load_use();
    test_store_forward();
    test_no_stall();
    test_branch_flush();
    test_halt_drain();
    test_reset_in_drain();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
